// File: rtl/fanout_fork_buffer.sv
// fanout_fork_buffer: registered eager-fork stage; holds each token until every enabled
// destination has taken it, tracking per-destination acceptance.
// Optional macro FANOUT_FORK_SKID_EN adds a tail entry (2-deep) with a fully registered in_ready.
module fanout_fork_buffer #(
    parameter int NUM_OUT = 6,
    parameter int DATA_W  = 17
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_OUT-1:0] cfg_out_en,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [NUM_OUT-1:0] out_valid,
    input  logic [NUM_OUT-1:0] out_ready
);
    logic               r_full;
    logic [DATA_W-1:0]  r_data;
    logic [NUM_OUT-1:0] r_pend;
    logic               w_n_full;
    logic [DATA_W-1:0]  w_n_data;
    logic [NUM_OUT-1:0] w_n_pend;
    logic [NUM_OUT-1:0] w_valid;
    logic [NUM_OUT-1:0] w_remain;
    logic               w_last;
    logic               w_head_free;
    logic               w_load;

    assign w_valid     = {NUM_OUT{r_full}} & r_pend;
    assign w_remain    = r_pend & ~(w_valid & out_ready);
    assign w_last      = r_full & (w_remain == '0);
    assign w_head_free = ~r_full | w_last;
    assign w_load      = in_valid & in_ready & (cfg_out_en != '0);
    assign out_valid   = reset ? '0 : w_valid;
    assign out_data    = reset ? '0 : r_data;

`ifdef FANOUT_FORK_SKID_EN
    logic               r_tfull;
    logic [DATA_W-1:0]  r_tdata;
    logic [NUM_OUT-1:0] r_tpend;
    logic               w_n_tfull;
    logic [DATA_W-1:0]  w_n_tdata;
    logic [NUM_OUT-1:0] w_n_tpend;

    assign in_ready = ~reset & ~r_tfull;

    // Head refills from the tail first (keeps order), else straight from the input; tail catches input while head is busy
    always_comb begin
        w_n_full  = r_full;
        w_n_data  = r_data;
        w_n_pend  = w_remain;
        w_n_tfull = r_tfull;
        w_n_tdata = r_tdata;
        w_n_tpend = r_tpend;
        if (w_head_free) begin
            if (r_tfull) begin
                w_n_full  = 1'b1;
                w_n_data  = r_tdata;
                w_n_pend  = r_tpend;
                w_n_tfull = 1'b0;
                w_n_tpend = '0;
            end else if (w_load) begin
                w_n_full = 1'b1;
                w_n_data = in_data;
                w_n_pend = cfg_out_en;
            end else begin
                w_n_full = 1'b0;
                w_n_pend = '0;
            end
        end else if (w_load) begin
            w_n_tfull = 1'b1;
            w_n_tdata = in_data;
            w_n_tpend = cfg_out_en;
        end
    end

    // Tail entry register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tfull <= 1'b0;
            r_tdata <= '0;
            r_tpend <= '0;
        end else begin
            r_tfull <= w_n_tfull;
            r_tdata <= w_n_tdata;
            r_tpend <= w_n_tpend;
        end
    end
`else
    assign in_ready = ~reset & w_head_free;

    // A load overrides the drain of the previous token; an all-zero mask sinks the token
    always_comb begin
        w_n_full = r_full;
        w_n_data = r_data;
        w_n_pend = w_remain;
        if (w_head_free) begin
            w_n_full = w_load;
            w_n_pend = w_load ? cfg_out_en : '0;
            w_n_data = w_load ? in_data : r_data;
        end
    end
`endif

    // Head entry register driving the outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_full <= 1'b0;
            r_data <= '0;
            r_pend <= '0;
        end else begin
            r_full <= w_n_full;
            r_data <= w_n_data;
            r_pend <= w_n_pend;
        end
    end
endmodule

// File: tb/tb_fanout_fork_buffer.sv
// tb_fanout_fork_buffer: directed stimulus, queue-based token model and literal checks.
module tb_fanout_fork_buffer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  cfg_out_en = '0;
    logic [16:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [16:0] out_data;
    logic [5:0]  out_valid;
    logic [5:0]  out_ready = '0;
    int          n_tests = 0;
    int          n_fail = 0;

`ifdef FANOUT_FORK_SKID_EN
    localparam logic STALL_IR = 1'b1;
`else
    localparam logic STALL_IR = 1'b0;
`endif

    typedef struct {
        logic [16:0] d;
        logic [5:0]  p;
    } tok_t;
    tok_t q[$];

    fanout_fork_buffer #(.NUM_OUT(6), .DATA_W(17)) dut (
        .clk(clk), .reset(reset), .cfg_out_en(cfg_out_en), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic probe;
        @(negedge clk);
        #1;
    endtask

    // Model: queue of held tokens with the destinations each still owes; head is what is offered
    always @(negedge clk) begin
        logic [5:0] ev;
        logic       eir;
        tok_t       t;
        ev = (reset || q.size() == 0) ? 6'd0 : q[0].p;
`ifdef FANOUT_FORK_SKID_EN
        eir = !reset && q.size() < 2;
`else
        eir = !reset && (q.size() == 0 || (q[0].p & ~out_ready) == 6'd0);
`endif
        chk("model out_valid", {26'd0, out_valid}, {26'd0, ev});
        chk("model in_ready", {31'd0, in_ready}, {31'd0, eir});
        if (ev != 6'd0) chk("model out_data", {15'd0, out_data}, {15'd0, q[0].d});
        if (reset) q.delete();
        else begin
            if (q.size() != 0) begin
                t = q[0];
                t.p = t.p & ~out_ready;
                if (t.p == 6'd0) void'(q.pop_front());
                else q[0] = t;
            end
            if (in_valid && eir && cfg_out_en != 6'd0) begin
                t.d = in_data;
                t.p = cfg_out_en;
                q.push_back(t);
            end
        end
    end

    initial begin
        tick;
        probe;
        chk("reset out_valid", {26'd0, out_valid}, 32'h0);
        chk("reset in_ready", {31'd0, in_ready}, 32'h0);
        chk("reset out_data", {15'd0, out_data}, 32'h0);
        tick;
        reset = 1'b0;
        cfg_out_en = 6'h3F;
        out_ready = 6'h3F;
        in_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            in_data = 17'(k);
            probe;
            chk("t1 in_ready", {31'd0, in_ready}, 32'h1);
            if (k > 1) begin
                chk("t1 out_data", {15'd0, out_data}, 32'(k - 1));
                chk("t1 out_valid", {26'd0, out_valid}, 32'h3F);
            end
            tick;
        end
        in_valid = 1'b0;
        probe;
        chk("t1 last data", {15'd0, out_data}, 32'h4);
        chk("t1 last valid", {26'd0, out_valid}, 32'h3F);
        tick;
        cfg_out_en = 6'b000101;
        in_data = 17'h1ABCD;
        in_valid = 1'b1;
        out_ready = 6'b000001;
        probe;
        chk("t2 empty valid", {26'd0, out_valid}, 32'h0);
        tick;
        in_valid = 1'b0;
        probe;
        chk("t2 first valid", {26'd0, out_valid}, 32'h05);
        chk("t2 data", {15'd0, out_data}, 32'h1ABCD);
        chk("t2 stall ready", {31'd0, in_ready}, {31'd0, STALL_IR});
        tick;
        probe;
        chk("t2 stall valid a", {26'd0, out_valid}, 32'h04);
        tick;
        probe;
        chk("t2 stall valid b", {26'd0, out_valid}, 32'h04);
        tick;
        out_ready = 6'b000101;
        probe;
        chk("t2 release valid", {26'd0, out_valid}, 32'h04);
        chk("t2 release ready", {31'd0, in_ready}, 32'h1);
        tick;
        probe;
        chk("t2 freed", {26'd0, out_valid}, 32'h0);
        tick;
        cfg_out_en = 6'd0;
        in_data = 17'h00055;
        in_valid = 1'b1;
        out_ready = 6'd0;
        probe;
        chk("t3 sink ready", {31'd0, in_ready}, 32'h1);
        tick;
        in_valid = 1'b0;
        probe;
        chk("t3 dropped", {26'd0, out_valid}, 32'h0);
        chk("t3 ready after", {31'd0, in_ready}, 32'h1);
        tick;
        cfg_out_en = 6'b000010;
        in_data = 17'h00777;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        cfg_out_en = 6'h3F;
        probe;
        chk("t4 held valid", {26'd0, out_valid}, 32'h02);
        chk("t4 stall ready", {31'd0, in_ready}, {31'd0, STALL_IR});
        tick;
        out_ready = 6'h3F;
        in_data = 17'h00888;
        in_valid = 1'b1;
        probe;
        chk("t4 cfg ignored", {26'd0, out_valid}, 32'h02);
        chk("t4 last ready", {31'd0, in_ready}, 32'h1);
        tick;
        in_valid = 1'b0;
        probe;
        chk("t4 new mask", {26'd0, out_valid}, 32'h3F);
        chk("t4 new data", {15'd0, out_data}, 32'h00888);
        tick;
        out_ready = 6'd0;
        cfg_out_en = 6'b110000;
        in_data = 17'h12345;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        probe;
        chk("t5 held", {26'd0, out_valid}, 32'h30);
        tick;
        reset = 1'b1;
        probe;
        chk("t5 reset valid", {26'd0, out_valid}, 32'h0);
        chk("t5 reset ready", {31'd0, in_ready}, 32'h0);
        chk("t5 reset data", {15'd0, out_data}, 32'h0);
        tick;
        reset = 1'b0;
        probe;
        chk("t5 post ready", {31'd0, in_ready}, 32'h1);
        chk("t5 no stale", {26'd0, out_valid}, 32'h0);
        tick;
        probe;
        chk("t5 still clear", {26'd0, out_valid}, 32'h0);
`ifdef FANOUT_FORK_SKID_EN
        tick;
        cfg_out_en = 6'h3F;
        out_ready = 6'd0;
        in_data = 17'h000A1;
        in_valid = 1'b1;
        tick;
        in_data = 17'h000A2;
        probe;
        chk("t6 head", {15'd0, out_data}, 32'h000A1);
        chk("t6 tail open", {31'd0, in_ready}, 32'h1);
        tick;
        in_valid = 1'b0;
        probe;
        chk("t6 full", {31'd0, in_ready}, 32'h0);
        tick;
        out_ready = 6'h3F;
        probe;
        chk("t6 registered ready", {31'd0, in_ready}, 32'h0);
        chk("t6 first out", {15'd0, out_data}, 32'h000A1);
        tick;
        probe;
        chk("t6 second out", {15'd0, out_data}, 32'h000A2);
        chk("t6 second valid", {26'd0, out_valid}, 32'h3F);
        chk("t6 ready back", {31'd0, in_ready}, 32'h1);
        tick;
        probe;
        chk("t6 drained", {26'd0, out_valid}, 32'h0);
`endif
        tick;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
